// File: rtl/mem_access.sv
// RV32I memory stage: non-memory results pass to writeback after one cycle; loads/stores run a
// req/ack data-memory transaction. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef L_type
`define L_type 2
`endif
`ifndef S_type
`define S_type 3
`endif

module mem_access #(
  parameter int OPC_W  = `OPCODE_WIDTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ce,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [2:0]        i_func3,
  input  logic [31:0]       i_y,
  input  logic [31:0]       i_rs2,
  input  logic [31:0]       i_rd,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_wr_reg_valid,
  output logic              o_stall,
  output logic              o_ce,
  output logic [31:0]       o_rd,
  output logic [4:0]        o_rd_addr,
  output logic              o_wr_reg_valid,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              o_misalign,
  output logic [31:0]       o_misalign_addr
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
  state_t state_reg, state_next;

  logic        ce_reg, ce_next, wrv_reg, wrv_next, req_reg, req_next;
  logic [31:0] rd_reg, rd_next, hold_reg, hold_next;
  logic [4:0]  rd_addr_reg, rd_addr_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [2:0]        f3_reg;
  logic [1:0]        lane_reg;
  logic [4:0]        txn_rd_addr_reg;
  logic              txn_wrv_reg;

  logic        accept, is_load, is_store, is_mem, misaligned, issue;
  logic [31:0] st_wdata, load_val, ack_result;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_opcode;

  assign unused_opcode = ^i_opcode;
  assign is_load  = i_opcode[`L_type];
  assign is_store = i_opcode[`S_type];
  assign is_mem   = is_load | is_store;
  assign accept   = i_ce && !i_flush && !i_stall && (state_reg == IDLE);
  assign issue    = accept && is_mem && !misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_reg;
  logic [31:0] misalign_addr_reg;

  always_comb begin
    misaligned = 1'b0;
    if (is_mem) begin
      case (i_func3[1:0])
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = i_y[0];
        default: misaligned = |i_y[1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_reg      <= 1'b0;
      misalign_addr_reg <= 32'd0;
    end else begin
      misalign_reg <= accept && misaligned;
      if (accept && misaligned) misalign_addr_reg <= i_y;
    end
  end

  assign o_misalign      = misalign_reg;
  assign o_misalign_addr = misalign_addr_reg;
`else
  assign misaligned = 1'b0;
`endif

  // Store lanes: data is replicated so the strobe alone selects the written bytes.
  always_comb begin
    case (i_func3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << i_y[1:0];
        st_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << {i_y[1], 1'b0};
        st_wdata = {2{i_rs2[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = i_rs2;
      end
    endcase
  end

  assign ld_byte = i_mem_rdata[{lane_reg, 3'b000} +: 8];
  assign ld_half = i_mem_rdata[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_reg[1:0])
      2'b00:   load_val = {{24{~f3_reg[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~f3_reg[2] & ld_half[15]}}, ld_half};
      default: load_val = i_mem_rdata;
    endcase
  end

  assign ack_result = we_reg ? 32'd0 : load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (issue) state_next = WAIT;
      WAIT:    if (i_mem_ack) state_next = i_stall ? HOLD : IDLE;
      HOLD:    if (!i_stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writeback outputs hold their value (including o_ce) whenever writeback stalls.
  always_comb begin
    o_stall      = (state_reg != IDLE) || i_stall;
    ce_next      = i_stall ? ce_reg : 1'b0;
    rd_next      = rd_reg;
    rd_addr_next = rd_addr_reg;
    wrv_next     = wrv_reg;
    req_next     = req_reg;
    hold_next    = hold_reg;
    case (state_reg)
      IDLE: begin
        if (accept && !is_mem) begin
          ce_next      = 1'b1;
          rd_next      = i_rd;
          rd_addr_next = i_rd_addr;
          wrv_next     = i_wr_reg_valid && (i_rd_addr != 5'd0);
        end else if (issue) begin
          req_next = 1'b1;
        end
      end
      WAIT: begin
        if (i_mem_ack) begin
          req_next = 1'b0;
          if (!i_stall) begin
            ce_next      = 1'b1;
            rd_next      = ack_result;
            rd_addr_next = txn_rd_addr_reg;
            wrv_next     = txn_wrv_reg;
          end else begin
            hold_next = ack_result;
          end
        end
      end
      HOLD: begin
        if (!i_stall) begin
          ce_next      = 1'b1;
          rd_next      = hold_reg;
          rd_addr_next = txn_rd_addr_reg;
          wrv_next     = txn_wrv_reg;
        end
      end
      default: req_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_reg          <= 1'b0;
      rd_reg          <= 32'd0;
      rd_addr_reg     <= 5'd0;
      wrv_reg         <= 1'b0;
      req_reg         <= 1'b0;
      hold_reg        <= 32'd0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= 32'd0;
      wstrb_reg       <= 4'd0;
      f3_reg          <= 3'd0;
      lane_reg        <= 2'd0;
      txn_rd_addr_reg <= 5'd0;
      txn_wrv_reg     <= 1'b0;
    end else begin
      ce_reg      <= ce_next;
      rd_reg      <= rd_next;
      rd_addr_reg <= rd_addr_next;
      wrv_reg     <= wrv_next;
      req_reg     <= req_next;
      hold_reg    <= hold_next;
      if (issue) begin
        we_reg          <= is_store;
        addr_reg        <= {i_y[ADDR_W-1:2], 2'b00};
        wdata_reg       <= is_store ? st_wdata : 32'd0;
        wstrb_reg       <= is_store ? st_wstrb : 4'd0;
        f3_reg          <= i_func3;
        lane_reg        <= i_y[1:0];
        txn_rd_addr_reg <= i_rd_addr;
        txn_wrv_reg     <= i_wr_reg_valid && !is_store && (i_rd_addr != 5'd0);
      end
    end
  end

  assign o_ce           = ce_reg;
  assign o_rd           = rd_reg;
  assign o_rd_addr      = rd_addr_reg;
  assign o_wr_reg_valid = wrv_reg;
  assign o_mem_req      = req_reg;
  assign o_mem_we       = we_reg;
  assign o_mem_addr     = addr_reg;
  assign o_mem_wdata    = wdata_reg;
  assign o_mem_wstrb    = wstrb_reg;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed vector table, hand-written handshake corner cases and
// randomized transactions checked against a behavioural load/store model.
module tb_mem_access;
  localparam int OPC_W   = 11;
  localparam int L_BIT   = 2;
  localparam int S_BIT   = 3;
  localparam int ALU_BIT = 0;
  localparam int LUI_BIT = 7;
  localparam int NV      = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_ce = 1'b0, i_flush = 1'b0, i_stall = 1'b0;
  logic [OPC_W-1:0] i_opcode = '0;
  logic [2:0]  i_func3 = 3'd0;
  logic [31:0] i_y = 32'd0, i_rs2 = 32'd0, i_rd = 32'd0;
  logic [4:0]  i_rd_addr = 5'd0;
  logic        i_wr_reg_valid = 1'b0;
  logic        o_stall, o_ce, o_wr_reg_valid, o_mem_req, o_mem_we;
  logic [31:0] o_rd, o_mem_addr, o_mem_wdata;
  logic [4:0]  o_rd_addr;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        o_misalign;
  logic [31:0] o_misalign_addr;
`endif

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset), .i_ce(i_ce), .i_flush(i_flush), .i_stall(i_stall),
    .i_opcode(i_opcode), .i_func3(i_func3), .i_y(i_y), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_rd_addr(i_rd_addr), .i_wr_reg_valid(i_wr_reg_valid), .o_stall(o_stall), .o_ce(o_ce),
    .o_rd(o_rd), .o_rd_addr(o_rd_addr), .o_wr_reg_valid(o_wr_reg_valid), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    , .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
`endif
  );

  typedef struct {
    logic [OPC_W-1:0] op;
    logic [2:0]  f3;
    logic [31:0] y, rs2, rd;
    logic [4:0]  rda;
    logic        wrv;
    logic [31:0] rdata;
    logic        ereq, ewe;
    logic [31:0] eaddr, ewdata;
    logic [3:0]  estrb;
    logic [31:0] erd;
    logic        ewrv;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPC_W-1:0] onehot(input int b);
    logic [OPC_W-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Reference load: shift the addressed lane down, mask to size, sign-extend arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 4'(1 << (a % 4));
      3'b001:  return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'b000:  return {24'd0, rs2[7:0]} * 32'h01010101;
      3'b001:  return {16'd0, rs2[15:0]} * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  function automatic vec_t mk(input logic [OPC_W-1:0] op, input logic [2:0] f3,
                              input logic [31:0] y, input logic [31:0] rs2, input logic [31:0] rd,
                              input logic [4:0] rda, input logic wrv, input logic [31:0] rdata,
                              input logic ereq, input logic ewe, input logic [31:0] eaddr,
                              input logic [31:0] ewdata, input logic [3:0] estrb,
                              input logic [31:0] erd, input logic ewrv);
    vec_t v;
    v.op = op; v.f3 = f3; v.y = y; v.rs2 = rs2; v.rd = rd; v.rda = rda; v.wrv = wrv;
    v.rdata = rdata; v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewdata = ewdata;
    v.estrb = estrb; v.erd = erd; v.ewrv = ewrv;
    return v;
  endfunction

  task automatic drive(input logic [OPC_W-1:0] op, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2, input logic [31:0] rd, input logic [4:0] rda,
                       input logic wrv);
    i_opcode = op; i_func3 = f3; i_y = y; i_rs2 = rs2; i_rd = rd;
    i_rd_addr = rda; i_wr_reg_valid = wrv; i_ce = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [NV];
    vec_t v;
    int   stall_cnt, ce_cnt;
    logic [31:0] seen_rd;

    vecs[0]  = mk(onehot(S_BIT), 3'b000, 32'h103, 32'hAB, 0, 5, 1, 0,
                  1, 1, 32'h100, 32'hABABABAB, 4'b1000, 0, 0);
    vecs[1]  = mk(onehot(L_BIT), 3'b000, 32'h102, 0, 0, 7, 1, 32'h80FF1234,
                  1, 0, 32'h100, 0, 4'b0000, 32'hFFFFFFFF, 1);
    vecs[2]  = mk(onehot(L_BIT), 3'b101, 32'h102, 0, 0, 8, 1, 32'h80FF1234,
                  1, 0, 32'h100, 0, 4'b0000, 32'h000080FF, 1);
    vecs[3]  = mk(onehot(ALU_BIT), 3'b000, 32'h5, 0, 32'h5, 3, 1, 0,
                  0, 0, 0, 0, 0, 32'h5, 1);
    vecs[4]  = mk(onehot(S_BIT), 3'b001, 32'h206, 32'h1234BEEF, 0, 6, 1, 0,
                  1, 1, 32'h204, 32'hBEEFBEEF, 4'b1100, 0, 0);
    vecs[5]  = mk(onehot(S_BIT), 3'b010, 32'h308, 32'hDEADBEEF, 0, 1, 0, 0,
                  1, 1, 32'h308, 32'hDEADBEEF, 4'b1111, 0, 0);
    vecs[6]  = mk(onehot(L_BIT), 3'b001, 32'h100, 0, 0, 9, 1, 32'h00008001,
                  1, 0, 32'h100, 0, 4'b0000, 32'hFFFF8001, 1);
    vecs[7]  = mk(onehot(L_BIT), 3'b100, 32'h101, 0, 0, 10, 1, 32'h00008001,
                  1, 0, 32'h100, 0, 4'b0000, 32'h00000080, 1);
    vecs[8]  = mk(onehot(L_BIT), 3'b000, 32'h101, 0, 0, 11, 1, 32'h00008001,
                  1, 0, 32'h100, 0, 4'b0000, 32'hFFFFFF80, 1);
    vecs[9]  = mk(onehot(L_BIT), 3'b010, 32'h400, 0, 0, 0, 1, 32'hCAFEF00D,
                  1, 0, 32'h400, 0, 4'b0000, 32'hCAFEF00D, 0);
    vecs[10] = mk(onehot(L_BIT), 3'b011, 32'h404, 0, 0, 31, 1, 32'h12345678,
                  1, 0, 32'h404, 0, 4'b0000, 32'h12345678, 1);
    vecs[11] = mk(onehot(LUI_BIT), 3'b000, 32'h10, 0, 32'hABCD0000, 4, 0, 0,
                  0, 0, 0, 0, 0, 32'hABCD0000, 0);
    vecs[12] = mk(onehot(L_BIT), 3'b000, 32'h103, 0, 0, 12, 1, 32'h7F000000,
                  1, 0, 32'h100, 0, 4'b0000, 32'h0000007F, 1);
    vecs[13] = mk(onehot(L_BIT), 3'b101, 32'h100, 0, 0, 13, 1, 32'hFFFFA5A5,
                  1, 0, 32'h100, 0, 4'b0000, 32'h0000A5A5, 1);

    // Reset state, with a stray ack during reset.
    i_mem_ack = 1'b1;
    tick(); tick();
    check("rst o_ce", o_ce, 0);
    check("rst o_rd", o_rd, 0);
    check("rst o_rd_addr", o_rd_addr, 0);
    check("rst o_wr_reg_valid", o_wr_reg_valid, 0);
    check("rst o_mem_req", o_mem_req, 0);
    check("rst o_mem_we", o_mem_we, 0);
    check("rst o_mem_addr", o_mem_addr, 0);
    check("rst o_mem_wdata", o_mem_wdata, 0);
    check("rst o_mem_wstrb", o_mem_wstrb, 0);
    check("rst o_stall", o_stall, 0);
    reset = 1'b0;
    tick();
    i_mem_ack = 1'b0;
    check("post-rst ack o_ce", o_ce, 0);
    check("post-rst ack o_stall", o_stall, 0);

    // Directed vector table, ack one cycle after request.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.op, v.f3, v.y, v.rs2, v.rd, v.rda, v.wrv);
      tick();
      i_ce = 1'b0;
      check($sformatf("vec%0d req", i), o_mem_req, v.ereq);
      if (v.ereq) begin
        check($sformatf("vec%0d we", i), o_mem_we, v.ewe);
        check($sformatf("vec%0d addr", i), o_mem_addr, v.eaddr);
        check($sformatf("vec%0d wstrb", i), o_mem_wstrb, v.estrb);
        if (v.ewe) check($sformatf("vec%0d wdata", i), o_mem_wdata, v.ewdata);
        check($sformatf("vec%0d ce in wait", i), o_ce, 0);
        check($sformatf("vec%0d stall in wait", i), o_stall, 1);
        tick();
        i_mem_ack = 1'b1;
        i_mem_rdata = v.rdata;
        tick();
        i_mem_ack = 1'b0;
        check($sformatf("vec%0d req drop", i), o_mem_req, 0);
      end
      check($sformatf("vec%0d ce", i), o_ce, 1);
      if (!v.ewe) check($sformatf("vec%0d rd", i), o_rd, v.erd);
      if (!v.ewe) check($sformatf("vec%0d rd_addr", i), o_rd_addr, v.rda);
      check($sformatf("vec%0d wr_reg_valid", i), o_wr_reg_valid, v.ewrv);
      tick();
      check($sformatf("vec%0d ce pulse", i), o_ce, 0);
    end

    // LW with ack three cycles after req: four stall cycles, one o_ce.
    drive(onehot(L_BIT), 3'b010, 32'h500, 0, 0, 2, 1);
    tick();
    i_ce = 1'b0;
    stall_cnt = 0;
    ce_cnt = 0;
    seen_rd = 32'd0;
    for (int c = 0; c < 8; c++) begin
      i_mem_ack = (c == 3);
      i_mem_rdata = 32'h600DF00D;
      if (o_stall) stall_cnt++;
      if (o_ce) begin
        ce_cnt++;
        seen_rd = o_rd;
      end
      tick();
    end
    i_mem_ack = 1'b0;
    check("lw3 stall cycles", stall_cnt, 4);
    check("lw3 ce count", ce_cnt, 1);
    check("lw3 rd", seen_rd, 32'h600DF00D);

    // Writeback stalled at ack: result held, delivered once the stall clears.
    drive(onehot(L_BIT), 3'b010, 32'h604, 0, 0, 12, 1);
    tick();
    i_ce = 1'b0;
    tick();
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hA5A50001;
    i_stall = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    i_mem_rdata = 32'h0;
    check("hold req drop", o_mem_req, 0);
    check("hold ce", o_ce, 0);
    tick();
    check("hold ce 2", o_ce, 0);
    i_stall = 1'b0;
    #1;
    check("hold stall", o_stall, 1);
    tick();
    check("hold release ce", o_ce, 1);
    check("hold release rd", o_rd, 32'hA5A50001);
    check("hold release rd_addr", o_rd_addr, 12);
    check("hold release stall", o_stall, 0);
    i_stall = 1'b1;
    tick();
    check("ce held under stall", o_ce, 1);
    check("rd frozen under stall", o_rd, 32'hA5A50001);
    i_stall = 1'b0;
    tick();
    check("ce drop after stall", o_ce, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    drive(onehot(L_BIT), 3'b010, 32'h102, 0, 0, 3, 1);
    tick();
    i_ce = 1'b0;
    check("trap misalign", o_misalign, 1);
    check("trap addr", o_misalign_addr, 32'h102);
    check("trap req", o_mem_req, 0);
    check("trap ce", o_ce, 0);
    tick();
    check("trap pulse", o_misalign, 0);
    check("trap req later", o_mem_req, 0);
`else
    drive(onehot(L_BIT), 3'b010, 32'h102, 0, 0, 3, 1);
    tick();
    i_ce = 1'b0;
    check("unaligned lw req", o_mem_req, 1);
    check("unaligned lw addr", o_mem_addr, 32'h100);
    tick();
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h80FF1234;
    tick();
    i_mem_ack = 1'b0;
    check("unaligned lw rd", o_rd, 32'h80FF1234);
    tick();
`endif

    // Reset in WAIT: request drops at once, a late ack is ignored.
    drive(onehot(L_BIT), 3'b010, 32'h700, 0, 0, 4, 1);
    tick();
    i_ce = 1'b0;
    tick();
    check("wait req before reset", o_mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("reset drops req", o_mem_req, 0);
    check("reset clears stall", o_stall, 0);
    tick();
    reset = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h11111111;
    tick();
    i_mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("late ack ce", o_ce, 0);
      check("late ack req", o_mem_req, 0);
      tick();
    end

    // Randomized transactions against the behavioural model.
    for (int t = 0; t < 300; t++) begin
      int kind, b, tries, d, k;
      logic [OPC_W-1:0] op;
      logic [2:0]  f3;
      logic [31:0] y, rs2, rd, rdata, exp_rd;
      logic [4:0]  rda;
      logic        wrv, fl, st, s, accepted, killed, is_st;

      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      y    = $urandom;
      rs2  = $urandom;
      rd   = $urandom;
      rda  = 5'($urandom_range(0, 31));
      wrv  = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        b = $urandom_range(0, 8);
        if (b >= 2) b += 2;
        op = onehot(b);
      end else if (kind == 1) begin
        op = onehot(L_BIT);
      end else begin
        op = onehot(S_BIT);
        f3 = 3'($urandom_range(0, 2));
      end
      is_st = (kind == 2);
`ifdef MEM_MISALIGN_TRAP_EN
      if (kind != 0) begin
        if (f3[1:0] == 2'b01) y[0] = 1'b0;
        else if (f3[1:0] != 2'b00) y[1:0] = 2'b00;
      end
`endif
      accepted = 1'b0;
      killed = 1'b0;
      tries = 0;
      while (!accepted && !killed && tries < 20) begin
        drive(op, f3, y, rs2, rd, rda, wrv);
        fl = ($urandom_range(0, 5) == 0);
        st = ($urandom_range(0, 3) == 0);
        i_flush = fl;
        i_stall = st;
        tick();
        tries++;
        if (fl || st) begin
          check("rnd no-accept req", o_mem_req, 0);
          check("rnd no-accept ce", o_ce, 0);
          if (fl) killed = 1'b1;
        end else begin
          accepted = 1'b1;
        end
      end
      i_ce = 1'b0;
      i_flush = 1'b0;
      i_stall = 1'b0;
      if (!accepted) continue;

      if (kind == 0) begin
        check("rnd alu req", o_mem_req, 0);
        check("rnd alu ce", o_ce, 1);
        check("rnd alu rd", o_rd, rd);
        check("rnd alu rd_addr", o_rd_addr, rda);
        check("rnd alu wrv", o_wr_reg_valid, wrv && (rda != 0));
        k = $urandom_range(0, 2);
        for (int c = 0; c < k; c++) begin
          i_stall = 1'b1;
          tick();
          check("rnd alu ce held", o_ce, 1);
          check("rnd alu rd held", o_rd, rd);
        end
        i_stall = 1'b0;
      end else begin
        check("rnd mem req", o_mem_req, 1);
        check("rnd mem we", o_mem_we, is_st);
        check("rnd mem addr", o_mem_addr, {y[31:2], 2'b00});
        check("rnd mem wstrb", o_mem_wstrb, is_st ? model_strb(f3, y) : 4'b0000);
        if (is_st) check("rnd mem wdata", o_mem_wdata, model_wdata(f3, rs2));
        check("rnd mem ce", o_ce, 0);
        d = $urandom_range(1, 4);
        for (int c = 0; c < d; c++) begin
          i_stall = ($urandom_range(0, 2) == 0);
          tick();
          check("rnd req held", o_mem_req, 1);
          check("rnd addr stable", o_mem_addr, {y[31:2], 2'b00});
        end
        rdata = $urandom;
        exp_rd = model_load(f3, y, rdata);
        s = ($urandom_range(0, 2) == 0);
        i_mem_ack = 1'b1;
        i_mem_rdata = rdata;
        i_stall = s;
        tick();
        i_mem_ack = 1'b0;
        i_mem_rdata = $urandom;
        check("rnd req drop", o_mem_req, 0);
        if (s) begin
          check("rnd hold ce", o_ce, 0);
          k = $urandom_range(0, 2);
          for (int c = 0; c < k; c++) begin
            tick();
            check("rnd hold ce wait", o_ce, 0);
            check("rnd hold stall", o_stall, 1);
          end
          i_stall = 1'b0;
          tick();
        end
        check("rnd mem done ce", o_ce, 1);
        if (!is_st) check("rnd load rd", o_rd, exp_rd);
        if (!is_st) check("rnd load rd_addr", o_rd_addr, rda);
        check("rnd mem wrv", o_wr_reg_valid, !is_st && wrv && (rda != 0));
      end
      tick();
      check("rnd ce once", o_ce, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
